// File: rtl/instr_sequencer.sv
// Issue stage: holds a loadable 18-bit micro-program and issues one registered
// A1/A2/A3/opcode/WE3 word per clock until HALT or end of memory. Optional SEQ_STEP_EN adds single-step gating.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int PCW   = $clog2(DEPTH) + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [17:0]              load_data,
    input  logic                     start,
`ifdef SEQ_STEP_EN
    input  logic                     step_mode,
    input  logic                     step,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [PCW-1:0]           pc,
    output logic [4:0]               A1,
    output logic [4:0]               A2,
    output logic [4:0]               A3,
    output logic [1:0]               opcode,
    output logic                     WE3
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [17:0] mem [DEPTH];
    logic [17:0] word;
    logic        fire;

`ifdef SEQ_STEP_EN
    assign fire = !step_mode || step;
`else
    assign fire = 1'b1;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // pc only reaches DEPTH through its top bit, which stands in for an implicit HALT
    assign word = pc[PCW-1] ? 18'h20000 : mem[pc[AW-1:0]];

    // Program memory is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (load_en && state != RUN)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (fire && word[17]) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc     <= '0;
            A1     <= '0;
            A2     <= '0;
            A3     <= '0;
            opcode <= '0;
            WE3    <= 1'b0;
        end else begin
            WE3 <= 1'b0;
            case (state)
                IDLE, DONE: if (start) pc <= '0;
                RUN: begin
                    if (fire && !word[17]) begin
                        opcode <= word[16:15];
                        A3     <= word[14:10];
                        A1     <= word[9:5];
                        A2     <= word[4:0];
                        WE3    <= 1'b1;
                        pc     <= pc + PCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level model predicts the issue
// stream, final pc and halt latency; a negedge monitor pops and compares.
module tb_instr_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PCW   = 5;

    logic           CLK = 1'b0;
    logic           RST;
    logic           load_en, start;
    logic [AW-1:0]  load_addr;
    logic [17:0]    load_data;
    logic           busy, done, WE3;
    logic [PCW-1:0] pc;
    logic [4:0]     A1, A2, A3;
    logic [1:0]     opcode;
`ifdef SEQ_STEP_EN
    logic step_mode = 1'b0, step = 1'b0;
`endif

    always #5 CLK = ~CLK;

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start),
`ifdef SEQ_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .busy(busy), .done(done), .pc(pc), .A1(A1), .A2(A2), .A3(A3),
        .opcode(opcode), .WE3(WE3)
    );

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0;
    logic [17:0] model [DEPTH];
    logic [16:0] exp_q[$];
    int          exp_pc_q[$];
    int          exp_lat_q[$];
    logic        done_d = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: every issued word and every done rise is matched against the scoreboard
    always @(negedge CLK) begin
        if (!RST) begin
            if (WE3) begin
                if (exp_q.size() == 0) check("unexpected_issue", {opcode, A3, A1, A2}, 17'h1ffff + 1);
                else check("issue", {opcode, A3, A1, A2}, exp_q.pop_front());
            end
            if (done && !done_d) begin
                if (exp_pc_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    int lat;
                    check("done_pc", pc, exp_pc_q.pop_front());
                    lat = exp_lat_q.pop_front();
                    if (lat >= 0) check("done_latency", cyc - start_cyc, lat);
                end
            end
        end
        done_d = done;
    end

    // Program-level prediction: words up to the first HALT (or end of memory) issue in order
    task automatic push_expect(input bit stepped);
        int p = 0;
        while (p < DEPTH && !model[p][17]) begin
            exp_q.push_back(model[p][16:0]);
            p++;
        end
        exp_pc_q.push_back(p);
        exp_lat_q.push_back(stepped ? -1 : p + 1);
    endtask

    task automatic load(input int a, input logic [17:0] d);
        @(negedge CLK);
        load_en = 1'b1; load_addr = AW'(a); load_data = d;
        model[a] = d;
        @(negedge CLK);
        load_en = 1'b0;
    endtask

    task automatic go(input bit with_load, input int a, input logic [17:0] d, input bit stepped);
        @(negedge CLK);
        if (with_load) begin
            model[a] = d;
            load_en = 1'b1; load_addr = AW'(a); load_data = d;
        end
        push_expect(stepped);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge CLK);
        start = 1'b0; load_en = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 200) begin @(negedge CLK); n++; end
        @(negedge CLK);
        check({nm, "_done_seen"}, done, 1);
        check({nm, "_drained"}, exp_q.size() + exp_pc_q.size(), 0);
        exp_q.delete(); exp_pc_q.delete(); exp_lat_q.delete();
    endtask

    function automatic logic [17:0] ins(input int op, input int a3, input int a1, input int a2);
        return {1'b0, 2'(op), 5'(a3), 5'(a1), 5'(a2)};
    endfunction

    initial begin
        RST = 1'b1; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge CLK);
        check("rst_pc", pc, 0);
        check("rst_fields", {A1, A2, A3, opcode}, 0);
        check("rst_we3", WE3, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RST = 1'b0;

        // Directed program with dependent second instruction
        load(0, ins(1, 3, 1, 2));
        load(1, ins(0, 4, 3, 3));
        load(2, 18'h20000);
        go(0, 0, 0, 0);
        wait_done("load_run");

        // Ignored load/start while running; memory and pc must be unaffected
        go(0, 0, 0, 0);
        load_en = 1'b1; load_addr = 1; load_data = ins(3, 31, 31, 31); start = 1'b1;
        @(negedge CLK);
        load_en = 1'b0; start = 1'b0;
        wait_done("ignored");
        go(0, 0, 0, 0);
        wait_done("rerun");

        // HALT at address 0, written on the same edge as start
        go(1, 0, 18'h20000 | 18'(1 << 16), 0);
        wait_done("imm_halt");
        check("imm_halt_pc", pc, 0);

        // Full memory without HALT
        for (int i = 0; i < DEPTH; i++) load(i, ins($urandom_range(3), $urandom_range(31), i, 31 - i));
        go(0, 0, 0, 0);
        wait_done("no_halt");
        check("no_halt_pc", pc, DEPTH);

        // Asynchronous reset while word 1 is on the outputs
        go(0, 0, 0, 0);
        @(posedge CLK); @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_we3", WE3, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        exp_q.delete(); exp_pc_q.delete(); exp_lat_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        go(0, 0, 0, 0);
        wait_done("after_rst");

        // Randomized programs, sometimes combining the last load with start
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [17:0] w = 18'($urandom);
                w[17] = ($urandom_range(5) == 0);
                load(i, w);
            end
            if ($urandom_range(1)) begin
                logic [17:0] w0 = 18'($urandom);
                w0[17] = ($urandom_range(7) == 0);
                go(1, 0, w0, 0);
            end else go(0, 0, 0, 0);
            wait_done("random");
        end

`ifdef SEQ_STEP_EN
        begin
            int steps = 0, n = 0;
            logic stepped_edge;
            load(0, ins(2, 5, 6, 7));
            load(1, ins(1, 8, 5, 5));
            load(2, 18'h20000);
            step_mode = 1'b1;
            go(0, 0, 0, 1);
            while (!done && n < 60) begin
                step = (n % 3 == 2);
                stepped_edge = step;
                if (step) steps++;
                @(negedge CLK);
                step = 1'b0;
                if (WE3) check("we3_only_on_step", stepped_edge, 1);
                n++;
            end
            check("step_count", steps, 3);
            wait_done("step");
            step_mode = 1'b0;
        end
`endif

        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream issue stage for the register-file/ALU datapath.
- Holds a small loadable program of 18-bit micro-instructions.
- On start, issues one instruction per clock as registered A1/A2/A3/opcode/WE3, which drive the datapath directly.
- Stops on a HALT instruction or at end of program memory.

Parameters:
- DEPTH, 16, number of instruction words (power of 2, ≥2).
- PCW, $clog2(DEPTH)+1, program-counter width; one extra bit so pc can equal DEPTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- load_en  input  1  write load_data into program memory at load_addr.
- load_addr  input  $clog2(DEPTH)  program write address.
- load_data  input  18  instruction word: [17] HALT, [16:15] opcode, [14:10] A3, [9:5] A1, [4:0] A2.
- start  input  1  begin execution from address 0.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE.
- pc  output  PCW  address of next instruction to fetch.
- A1  output  5  read address 1 to register file.
- A2  output  5  read address 2 to register file.
- A3  output  5  write address to register file.
- opcode  output  2  ALU operation.
- WE3  output  1  register-file write enable.

Behaviour:
- Reset (async, any state, including mid-run):
  - state=IDLE, pc=0, A1=A2=A3=0, opcode=0, WE3=0, busy=0, done=0.
  - Program memory is not reset.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from the state register, so there is no extra latency.
- Load:
  - Write occurs on an edge with load_en=1 in IDLE or DONE.
  - load_en in RUN is ignored; memory is unchanged.
- Start:
  - Edge with start=1 in IDLE or DONE: state←RUN, pc←0, WE3←0, other outputs hold.
  - start in RUN is ignored.
  - load_en and start on the same edge: the write is performed and start is taken. The written word is visible to the first fetch.
- RUN, each edge:
  - Fetch word w=mem[pc] (combinational read). When pc==DEPTH, w is an implicit HALT.
  - If w[17]=0: A3/A1/A2/opcode←fields, WE3←1, pc←pc+1.
  - If w[17]=1: WE3←0, state←DONE, pc holds, field outputs hold.
- Latency:
  - Instruction k appears on the outputs after the (k+2)th edge following start.
  - The datapath commits its write on the next edge.
  - Back-to-back dependent instructions need no bubbles: the register file writes at the edge and reads combinationally.
- WE3 is high only for edges that issued a non-HALT word. It is 0 in IDLE, in DONE, and in the first RUN cycle.
- Program length: N non-HALT words issue in N cycles. A HALT at address 0 issues nothing; done rises 2 edges after start.
- End of memory without HALT: after issuing address DEPTH-1, pc=DEPTH. The next edge acts as HALT.
- DONE persists until start or RST.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined: adds ports step_mode (input 1) and step (input 1).
  - In RUN with step_mode=1, a fetch/issue occurs only on edges with step=1.
  - On other edges: WE3←0, pc and field outputs hold, state stays RUN.
  - A HALT is also processed only on a step edge.
  - step_mode=0 gives normal behaviour.
- Undefined: ports absent; every RUN edge fetches.

Test Plan:
- Reset mid-run: assert RST during issue of word 2 -> WE3=0, pc=0, busy=0, done=0 immediately (asynchronously). Re-start reruns the loaded program unchanged.
- Load and run: load mem[0]=(op=1,A3=3,A1=1,A2=2), mem[1]=(op=0,A3=4,A1=3,A2=3), mem[2]=HALT, then pulse start.
  - Edge 2: A3=3, A1=1, A2=2, opcode=1, WE3=1.
  - Edge 3: A3=4, A1=3, A2=3, opcode=0, WE3=1.
  - Edge 4: WE3=0, done=1, pc=2.
- Immediate HALT: mem[0]=HALT, start -> WE3 never 1; done=1 after 2nd edge; pc=0.
- No HALT, DEPTH=16: fill all 16 non-HALT words, start -> 16 consecutive WE3=1 cycles; then pc=16, done=1.
- Ignored inputs: during RUN, load_en writes mem[1] and start pulses -> original mem[1] fields issued, pc not reset. After done, restart issues identical sequence.
- SEQ_STEP_EN: step_mode=1 with 2-word program, step pulsed every 3rd cycle -> exactly one WE3=1 cycle per step pulse; done after the third step.
